// File: rtl/sram_pkg.sv
// Shared types for the SRAM/LUTRAM reader blocks.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } reader_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for a valid/ready beat stream with a last flag.
// Loads a new beat whenever the slot is empty or being popped; flush drops it.
module stream_out_reg #(
    parameter int DWIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_req,
    input  logic              i_flush,
    input  logic [DWIDTH-1:0] i_din,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_last,
    output logic              o_load,
    output logic              o_pop
);

    assign o_pop  = o_valid && i_ready;
    assign o_load = i_load_req && !i_flush && (!o_valid || i_ready);

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else if (o_load) begin
            o_valid <= 1'b1;
            o_data  <= i_din;
            o_last  <= i_last;
        end else if (o_pop) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

    a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_valid && !i_ready && !i_flush) |=> (o_valid && $stable(o_data) && $stable(o_last)));

    a_last_with_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_last |-> o_valid);

endmodule

// File: rtl/lutram_stream_reader.sv
// Burst reader for the inferred LUTRAM: flopped read address, registered
// valid/ready output stream with last flag, synchronous abort.
module lutram_stream_reader
    import sram_pkg::*;
#(
    parameter  int DEPTH  = 1024,
    parameter  int DWIDTH = 32,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [AWIDTH-1:0] i_req_addr,
    input  logic [AWIDTH-1:0] i_req_len,
    input  logic              i_abort,
    output logic [AWIDTH-1:0] o_raddr,
    input  logic [DWIDTH-1:0] i_rdata,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_data_last,
    output logic              o_busy
);

    localparam bit POW2 = ((DEPTH & (DEPTH - 1)) == 0);

    reader_state_t     state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH-1:0] remain_q, remain_d;
    logic [AWIDTH-1:0] addr_inc;
    logic              load_req;
    logic              load;
    logic              pop;

    generate
        if (POW2) begin : g_wrap_pow2
            assign addr_inc = addr_q + 1'b1;
        end else begin : g_wrap_cmp
            assign addr_inc = (addr_q == AWIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        end
    endgenerate

    // Load request is kept out of the FSM process so load/next-state form no comb loop.
    assign load_req = (state_q == STREAM) && !i_abort;
    assign o_raddr  = addr_q;
    assign o_busy   = (state_q != IDLE);

    stream_out_reg #(
        .DWIDTH (DWIDTH)
    ) u_out (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load_req (load_req),
        .i_flush    (i_abort),
        .i_din      (i_rdata),
        .i_last     (remain_q == '0),
        .i_ready    (i_data_ready),
        .o_valid    (o_data_valid),
        .o_data     (o_data),
        .o_last     (o_data_last),
        .o_load     (load),
        .o_pop      (pop)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    // NOTE: every output of this process gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        o_req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_req_ready = !i_abort;
                if (i_req_valid && !i_abort) begin
                    addr_d   = i_req_addr;
                    remain_d = i_req_len;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (i_abort) begin
                    addr_d   = '0;
                    remain_d = '0;
                    state_d  = IDLE;
                end else if (load) begin
                    if (remain_q != '0) begin
                        addr_d   = addr_inc;
                        remain_d = remain_q - 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (i_abort) begin
                    addr_d   = '0;
                    remain_d = '0;
                    state_d  = IDLE;
                end else if (pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    a_addr_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_req_valid && o_req_ready) |-> (32'(i_req_addr) < DEPTH));

    a_last_pop_in_drain: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (pop && o_data_last && !i_abort) |-> (state_q == DRAIN));

    a_drain_holds_last: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q == DRAIN) |-> (o_data_valid && o_data_last));

    a_drain_exit_on_last: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q == DRAIN && state_d == IDLE && !i_abort) |-> (pop && o_data_last));

endmodule

// File: tb/tb_lutram_stream_reader.sv
// Self-checking bench: LUTRAM model, table-driven bursts, hand-written corner
// sequences and randomized bursts checked against an expected-beat queue.
module tb_lutram_stream_reader;

    localparam int DEPTH  = 16;
    localparam int DWIDTH = 32;
    localparam int AWIDTH = 4;

    logic              i_clk        = 1'b0;
    logic              i_rst_n      = 1'b0;
    logic              i_req_valid  = 1'b0;
    logic [AWIDTH-1:0] i_req_addr   = '0;
    logic [AWIDTH-1:0] i_req_len    = '0;
    logic              i_abort      = 1'b0;
    logic              i_data_ready = 1'b0;
    logic [DWIDTH-1:0] i_rdata;
    logic              o_req_ready;
    logic [AWIDTH-1:0] o_raddr;
    logic              o_data_valid;
    logic [DWIDTH-1:0] o_data;
    logic              o_data_last;
    logic              o_busy;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic              we    = 1'b0;
    logic [AWIDTH-1:0] waddr = '0;
    logic [DWIDTH-1:0] wdata = '0;

    int n_checks = 0;
    int n_err    = 0;

    lutram_stream_reader #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_len    (i_req_len),
        .i_abort      (i_abort),
        .o_raddr      (o_raddr),
        .i_rdata      (i_rdata),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_data       (o_data),
        .o_data_last  (o_data_last),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // LUTRAM model: synchronous write, combinational read.
    always @(posedge i_clk) if (we) mem[waddr] <= wdata;
    assign i_rdata = mem[o_raddr];

    typedef struct {
        logic        ready;
        logic        abort;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
        logic        exp_busy;
        logic [3:0]  exp_raddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic r, input logic a, input logic ev,
                                 input logic [31:0] d, input logic el,
                                 input logic eb, input logic [3:0] ra);
        vec_t v;
        v.ready = r; v.abort = a; v.exp_valid = ev; v.exp_data = d;
        v.exp_last = el; v.exp_busy = eb; v.exp_raddr = ra;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_word(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic request(input logic [AWIDTH-1:0] a, input logic [AWIDTH-1:0] l);
        int guard = 0;
        while (!o_req_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("req_ready_wait", {31'b0, o_req_ready}, 32'd1);
        i_req_valid = 1'b1; i_req_addr = a; i_req_len = l;
        tick();
        i_req_valid = 1'b0;
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[k]) begin
            i_data_ready = tbl[k].ready;
            i_abort      = tbl[k].abort;
            tick();
            check({tag, "_valid"}, {31'b0, o_data_valid}, {31'b0, tbl[k].exp_valid});
            check({tag, "_busy"},  {31'b0, o_busy},       {31'b0, tbl[k].exp_busy});
            check({tag, "_raddr"}, {28'b0, o_raddr},      {28'b0, tbl[k].exp_raddr});
            check({tag, "_last"},  {31'b0, o_data_last},  {31'b0, tbl[k].exp_last});
            if (tbl[k].exp_valid) check({tag, "_data"}, o_data, tbl[k].exp_data);
        end
        i_abort = 1'b0;
    endtask

    // Expected beats are the memory words at addr, addr+1, ... modulo DEPTH.
    task automatic run_burst(input int a, input int l, input bit patterned, input int budget);
        logic [31:0] exp_q[$];
        logic [31:0] held = '0;
        logic [31:0] exp;
        bit          stalled = 0;
        bit          rdy;
        int          cyc = 0;
        int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        for (int i = 0; i <= l; i++) exp_q.push_back(mem[(a + i) % DEPTH]);
        request(AWIDTH'(a), AWIDTH'(l));
        while (o_busy && cyc < budget) begin
            if (stalled) check("stall_hold", o_data, held);
            rdy = patterned ? (pat[cyc % 7] != 0) : ($urandom_range(0, 3) != 0);
            if (o_data_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat_data", o_data, exp);
                    check("beat_last", {31'b0, o_data_last}, {31'b0, exp_q.size() == 0});
                end
            end
            stalled      = o_data_valid && !rdy;
            held         = o_data;
            i_data_ready = rdy;
            tick();
            cyc++;
        end
        check("burst_done", {31'b0, o_busy}, 32'd0);
        check("beats_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", {31'b0, o_data_valid}, 32'd0);
        check("rst_busy",  {31'b0, o_busy},       32'd0);
        check("rst_raddr", {28'b0, o_raddr},      32'd0);
        check("rst_data",  o_data,                32'd0);
        check("rst_last",  {31'b0, o_data_last},  32'd0);
        i_rst_n = 1'b1;
        #1;
        check("rst_req_ready", {31'b0, o_req_ready}, 32'd1);

        for (int i = 0; i < DEPTH; i++) write_word(AWIDTH'(i), 32'hA0 + i);

        // Basic burst: addr 2, len 3, ready high
        i_data_ready = 1'b1;
        request(4'd2, 4'd3);
        check("t1_hs_valid", {31'b0, o_data_valid}, 32'd0);
        check("t1_hs_busy",  {31'b0, o_busy},       32'd1);
        check("t1_hs_raddr", {28'b0, o_raddr},      32'd2);
        tbl.delete();
        tbl.push_back(row(1, 0, 1, 32'hA2, 0, 1, 4'd3));
        tbl.push_back(row(1, 0, 1, 32'hA3, 0, 1, 4'd4));
        tbl.push_back(row(1, 0, 1, 32'hA4, 0, 1, 4'd5));
        tbl.push_back(row(1, 0, 1, 32'hA5, 1, 1, 4'd5));
        tbl.push_back(row(1, 0, 0, 32'h0,  0, 0, 4'd5));
        run_table("t1");
        check("t1_req_ready", {31'b0, o_req_ready}, 32'd1);

        // Wrap: addr 14, len 3
        request(4'd14, 4'd3);
        check("t2_hs_raddr", {28'b0, o_raddr}, 32'd14);
        tbl.delete();
        tbl.push_back(row(1, 0, 1, 32'hAE, 0, 1, 4'd15));
        tbl.push_back(row(1, 0, 1, 32'hAF, 0, 1, 4'd0));
        tbl.push_back(row(1, 0, 1, 32'hA0, 0, 1, 4'd1));
        tbl.push_back(row(1, 0, 1, 32'hA1, 1, 1, 4'd1));
        tbl.push_back(row(1, 0, 0, 32'h0,  0, 0, 4'd1));
        run_table("t2");

        // Backpressure pattern 1,0,0,1,1,0,1...
        run_burst(0, 4, 1'b1, 100);

        // Write ordering: write during stall is seen; same-edge write is not
        i_data_ready = 1'b0;
        request(4'd3, 4'd2);
        tick();
        check("t4_first",  o_data,           32'hA3);
        check("t4_raddr4", {28'b0, o_raddr}, 32'd4);
        we = 1'b1; waddr = 4'd4; wdata = 32'h55;
        tick();
        we = 1'b0;
        check("t4_stall_hold", o_data, 32'hA3);
        i_data_ready = 1'b1;
        tick();
        check("t4_new_data", o_data,           32'h55);
        check("t4_raddr5",   {28'b0, o_raddr}, 32'd5);
        we = 1'b1; waddr = 4'd5; wdata = 32'h66;
        tick();
        we = 1'b0;
        check("t4_same_edge_old", o_data,               32'hA5);
        check("t4_last",          {31'b0, o_data_last}, 32'd1);
        tick();
        check("t4_idle", {31'b0, o_busy}, 32'd0);
        run_burst(5, 0, 1'b0, 50);

        // Abort on the second beat of a len=7 burst
        i_data_ready = 1'b1;
        request(4'd0, 4'd7);
        tick();
        check("t5_beat0", o_data, 32'hA0);
        tick();
        check("t5_beat1_valid", {31'b0, o_data_valid}, 32'd1);
        check("t5_beat1",       o_data,                32'hA1);
        i_abort = 1'b1;
        tick();
        check("t5_ab_valid", {31'b0, o_data_valid}, 32'd0);
        check("t5_ab_last",  {31'b0, o_data_last},  32'd0);
        check("t5_ab_busy",  {31'b0, o_busy},       32'd0);
        check("t5_ab_raddr", {28'b0, o_raddr},      32'd0);
        check("t5_ab_block", {31'b0, o_req_ready},  32'd0);
        i_req_valid = 1'b1; i_req_addr = 4'd7; i_req_len = 4'd1;
        tick();
        check("t5_blocked_busy", {31'b0, o_busy}, 32'd0);
        i_req_valid = 1'b0;
        i_abort     = 1'b0;
        #1;
        check("t5_req_ready", {31'b0, o_req_ready}, 32'd1);
        run_burst(9, 2, 1'b0, 100);

        // Asynchronous reset mid-burst
        i_data_ready = 1'b1;
        request(4'd0, 4'd7);
        tick();
        tick();
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, o_data_valid}, 32'd0);
        check("t6_rst_busy",  {31'b0, o_busy},       32'd0);
        check("t6_rst_raddr", {28'b0, o_raddr},      32'd0);
        check("t6_rst_data",  o_data,                32'd0);
        tick();
        #3;
        i_rst_n = 1'b1;
        tick();
        check("t6_req_ready", {31'b0, o_req_ready}, 32'd1);
        run_burst(5, 3, 1'b0, 100);

        // Randomized bursts with random backpressure
        for (int n = 0; n < 20; n++) begin
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), 1'b0, 300);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
